// File: rtl/line_draw_pkg.sv
// line_draw_pkg: shared FSM states, register offsets and status bit positions for the line drawer.
package line_draw_pkg;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_ORDER = 2'd2;
  localparam logic [1:0] S_DRAW  = 2'd3;
  localparam logic [2:0] OFF_START = 3'd0;
  localparam logic [2:0] OFF_X0    = 3'd1;
  localparam logic [2:0] OFF_Y0    = 3'd2;
  localparam logic [2:0] OFF_X1    = 3'd3;
  localparam logic [2:0] OFF_Y1    = 3'd4;
  localparam logic [2:0] OFF_COLOR = 3'd5;
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
endpackage

// File: rtl/line_draw_engine.sv
// line_draw_engine: Bresenham FSM and datapath emitting one pixel per accepted cycle.
module line_draw_engine
  import line_draw_pkg::*;
#(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y1,
  input  logic [CW-1:0] color,
  output logic [XW-1:0] plot_x,
  output logic [YW-1:0] plot_y,
  output logic [CW-1:0] plot_color,
  output logic          plot_we,
  input  logic          plot_ready,
  output logic          busy,
  output logic          done
);
  localparam int N = XW > YW ? XW : YW;
  localparam int E = N + 2;
  logic [1:0] state;
  logic steep, ystep_up, stp, sw;
  logic [N-1:0] ex0, ey0, ex1, ey1, adx, ady;
  logic [N-1:0] ax0, ay0, ax1, ay1, ox0, oy0, ox1, oy1, odx, ody;
  logic [N-1:0] x, y, xe, dx, dy;
  logic [CW-1:0] col;
  logic signed [E-1:0] err, err_n;
  always_comb begin
    ex0 = N'(x0);
    ey0 = N'(y0);
    ex1 = N'(x1);
    ey1 = N'(y1);
    adx = ex1 > ex0 ? ex1 - ex0 : ex0 - ex1;
    ady = ey1 > ey0 ? ey1 - ey0 : ey0 - ey1;
    stp = ady > adx;
    sw  = ax0 > ax1;
    ox0 = sw ? ax1 : ax0;
    oy0 = sw ? ay1 : ay0;
    ox1 = sw ? ax0 : ax1;
    oy1 = sw ? ay0 : ay1;
    odx = ox1 - ox0;
    ody = oy1 > oy0 ? oy1 - oy0 : oy0 - oy1;
    err_n = err + $signed({2'b00, dy});
  end
  assign plot_x     = steep ? XW'(y) : XW'(x);
  assign plot_y     = steep ? YW'(x) : YW'(y);
  assign plot_color = col;
  assign plot_we    = state == S_DRAW;
  assign busy       = state != S_IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      done     <= 1'b0;
      steep    <= 1'b0;
      ystep_up <= 1'b0;
      ax0      <= '0;
      ay0      <= '0;
      ax1      <= '0;
      ay1      <= '0;
      x        <= '0;
      y        <= '0;
      xe       <= '0;
      dx       <= '0;
      dy       <= '0;
      col      <= '0;
      err      <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state <= S_LOAD;
          done  <= 1'b0;
        end
        S_LOAD: begin
          steep <= stp;
          ax0   <= stp ? ey0 : ex0;
          ay0   <= stp ? ex0 : ey0;
          ax1   <= stp ? ey1 : ex1;
          ay1   <= stp ? ex1 : ey1;
          col   <= color;
          state <= S_ORDER;
        end
        S_ORDER: begin
          x        <= ox0;
          y        <= oy0;
          xe       <= ox1;
          dx       <= odx;
          dy       <= ody;
          ystep_up <= oy0 < oy1;
          err      <= -$signed({2'b00, odx >> 1});
          state    <= S_DRAW;
        end
        default: if (plot_ready) begin
          if (x == xe) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end else begin
            x <= x + 1'b1;
            // the error term crossing zero is when the minor axis advances
            if (err_n >= 0) begin
              y   <= ystep_up ? y + 1'b1 : y - 1'b1;
              err <= err_n - $signed({2'b00, dx});
            end else begin
              err <= err_n;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/line_draw_mmio.sv
// line_draw_mmio: processor-facing decode, register file and registered status/readback port.
module line_draw_mmio
  import line_draw_pkg::*;
#(
  parameter logic [3:0] BASE = 4'h3,
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CW = 3
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic [15:0]   ADDR,
  input  logic [15:0]   DOUT,
  input  logic          W,
  output logic [15:0]   RDATA,
  output logic [XW-1:0] plot_x,
  output logic [YW-1:0] plot_y,
  output logic [CW-1:0] plot_color,
  output logic          plot_we,
  input  logic          plot_ready,
  output logic          busy
);
  logic sel, wr, done, unused;
  logic [2:0] off;
  logic [XW-1:0] x0, x1;
  logic [YW-1:0] y0, y1;
  logic [CW-1:0] color;
  logic [15:0] status, rd;
  assign sel    = ADDR[15:12] == BASE;
  assign off    = ADDR[2:0];
  assign wr     = sel && W;
  assign unused = ^{ADDR[11:3], DOUT};
  always_comb begin
    status = '0;
    status[ST_BUSY] = busy;
    status[ST_DONE] = done;
    rd = off == OFF_START ? status :
         off == OFF_X0    ? 16'(x0) :
         off == OFF_Y0    ? 16'(y0) :
         off == OFF_X1    ? 16'(x1) :
         off == OFF_Y1    ? 16'(y1) :
         off == OFF_COLOR ? 16'(color) : '0;
  end
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      x0    <= '0;
      y0    <= '0;
      x1    <= '0;
      y1    <= '0;
      color <= '0;
      RDATA <= '0;
    end else begin
      if (wr && off == OFF_X0) x0 <= DOUT[XW-1:0];
      if (wr && off == OFF_Y0) y0 <= DOUT[YW-1:0];
      if (wr && off == OFF_X1) x1 <= DOUT[XW-1:0];
      if (wr && off == OFF_Y1) y1 <= DOUT[YW-1:0];
      if (wr && off == OFF_COLOR) color <= DOUT[CW-1:0];
      if (sel) RDATA <= rd;
    end
  end
  line_draw_engine #(.XW(XW), .YW(YW), .CW(CW)) u_engine (
    .clk(Clock),
    .rst_n(Resetn),
    .start(wr && off == OFF_START),
    .x0(x0),
    .y0(y0),
    .x1(x1),
    .y1(y1),
    .color(color),
    .plot_x(plot_x),
    .plot_y(plot_y),
    .plot_color(plot_color),
    .plot_we(plot_we),
    .plot_ready(plot_ready),
    .busy(busy),
    .done(done)
  );
endmodule

// File: tb/tb_line_draw_mmio.sv
// tb_line_draw_mmio: directed and random line draws checked against an integer Bresenham model.
module tb_line_draw_mmio;
  import line_draw_pkg::*;
  localparam logic [3:0] BASE = 4'h3;
  logic Clock = 0, Resetn = 0, W = 0, plot_ready = 0, plot_we, busy;
  logic [15:0] ADDR = 0, DOUT = 0, RDATA;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [2:0] plot_color;
  int errs = 0, checks = 0;
  int exp_q[$];

  line_draw_mmio #(.BASE(BASE), .XW(8), .YW(7), .CW(3)) dut (
    .Clock(Clock), .Resetn(Resetn), .ADDR(ADDR), .DOUT(DOUT), .W(W), .RDATA(RDATA),
    .plot_x(plot_x), .plot_y(plot_y), .plot_color(plot_color), .plot_we(plot_we),
    .plot_ready(plot_ready), .busy(busy)
  );

  always #5 Clock = ~Clock;

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] off, input logic [15:0] d);
    ADDR = {BASE, 9'd0, off};
    DOUT = d;
    W = 1;
    tick;
    W = 0;
    ADDR = 0;
  endtask

  task automatic bus_rd(input logic [2:0] off);
    ADDR = {BASE, 9'd0, off};
    W = 0;
    tick;
    ADDR = 0;
  endtask

  function automatic int iabs(input int v);
    return v < 0 ? -v : v;
  endfunction

  // pixel list as x*256+y, in drawing order
  function automatic void model(input int x0, input int y0, input int x1, input int y1);
    int dx, dy, err, y, ys, t;
    bit steep;
    exp_q.delete();
    steep = iabs(y1 - y0) > iabs(x1 - x0);
    if (steep) begin
      t = x0; x0 = y0; y0 = t;
      t = x1; x1 = y1; y1 = t;
    end
    if (x0 > x1) begin
      t = x0; x0 = x1; x1 = t;
      t = y0; y0 = y1; y1 = t;
    end
    dx = x1 - x0;
    dy = iabs(y1 - y0);
    ys = y0 < y1 ? 1 : -1;
    err = -(dx / 2);
    y = y0;
    for (int x = x0; x <= x1; x++) begin
      exp_q.push_back(steep ? y * 256 + x : x * 256 + y);
      err += dy;
      if (err >= 0) begin
        y += ys;
        err -= dx;
      end
    end
  endfunction

  // mode 0: always ready; 1: random ready; 2: stall 3 cycles on second pixel with bus traffic
  task automatic draw(input int x0, input int y0, input int x1, input int y1, input int c,
                      input int mode, input bit wr_regs);
    int idx = 0, stall = 0, cyc = 0;
    bit was_stall = 0, rd_pend = 0;
    logic [18:0] held = '0;
    model(x0, y0, x1, y1);
    if (wr_regs) begin
      bus_wr(OFF_X0, 16'(x0));
      bus_wr(OFF_Y0, 16'(y0));
      bus_wr(OFF_X1, 16'(x1));
      bus_wr(OFF_Y1, 16'(y1));
      bus_wr(OFF_COLOR, 16'(c));
    end
    plot_ready = 1;
    bus_wr(OFF_START, 16'($urandom));
    chk("busy_after_start", busy, 1);
    tick;
    tick;
    chk("first_we", plot_we, 1);
    while (busy && cyc < 1000) begin
      plot_ready = mode == 1 ? ($urandom_range(2) != 0) : mode == 2 ? !(idx == 1 && stall < 3) : 1'b1;
      if (was_stall) chk("frozen", {plot_we, plot_x, plot_y, plot_color}, held);
      if (rd_pend) chk("status_busy", RDATA, 16'h0001);
      if (mode == 0) chk("we_consec", plot_we, 1);
      was_stall = plot_we && !plot_ready;
      held = {plot_we, plot_x, plot_y, plot_color};
      rd_pend = 0;
      if (plot_we && plot_ready) begin
        chk("pixel", {16'd0, plot_x, 1'b0, plot_y}, idx < exp_q.size() ? exp_q[idx] : -1);
        chk("color", plot_color, c);
        idx++;
      end
      if (mode == 2 && !plot_ready) begin
        ADDR = {BASE, 9'd0, stall == 1 ? OFF_X1 : OFF_START};
        DOUT = 16'd200;
        W = stall != 2;
        rd_pend = stall == 2;
        stall++;
      end
      tick;
      W = 0;
      ADDR = 0;
      cyc++;
    end
    chk("pixel_count", idx, exp_q.size());
    chk("done_in_budget", busy, 0);
    if (mode == 0) chk("draw_cycles", cyc, exp_q.size());
    bus_rd(OFF_START);
    chk("status_done", RDATA, 16'h0002);
  endtask

  initial begin
    #2;
    chk("rst_rdata", RDATA, 0);
    chk("rst_we", plot_we, 0);
    chk("rst_busy", busy, 0);
    #10 Resetn = 1;
    tick;
    for (int r = 1; r <= 5; r++) begin
      bus_rd(3'(r));
      chk("rst_reg", RDATA, 0);
    end
    draw(0, 0, 3, 0, 5, 0, 1);
    draw(0, 0, 1, 3, 2, 0, 1);
    draw(3, 2, 0, 0, 7, 0, 1);
    draw(7, 7, 7, 7, 1, 0, 1);
    draw(0, 0, 5, 2, 4, 2, 1);
    bus_rd(OFF_X1);
    chk("x1_readback", RDATA, 200);
    for (int k = 0; k < 6; k++)
      draw($urandom_range(159), $urandom_range(119), $urandom_range(159), $urandom_range(119),
           $urandom_range(7), 1, 1);
    bus_wr(OFF_X0, 0);
    bus_wr(OFF_Y0, 0);
    bus_wr(OFF_X1, 9);
    bus_wr(OFF_Y1, 4);
    bus_wr(OFF_COLOR, 6);
    plot_ready = 1;
    bus_wr(OFF_START, 1);
    tick;
    tick;
    tick;
    chk("pre_reset_we", plot_we, 1);
    Resetn = 0;
    #1;
    chk("mid_rst_we", plot_we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rdata", RDATA, 0);
    #2 Resetn = 1;
    tick;
    for (int r = 1; r <= 5; r++) begin
      bus_rd(3'(r));
      chk("post_rst_reg", RDATA, 0);
    end
    draw(0, 0, 0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/line_draw_mmio.md
Name: line_draw_mmio

Overview:
Memory-mapped Bresenham line-drawing peripheral that sits directly downstream of the multicycle processor. It decodes the processor's ADDR/DOUT/W write stream into endpoint, colour and start registers, and returns status through a registered read port feeding the processor's DIN mux. When started, it emits one framebuffer pixel write per cycle, with backpressure from the framebuffer.

Parameters:
BASE, 4'h3, ADDR[15:12] value that selects this block
XW, 8, x coordinate width (160-pixel screen)
YW, 7, y coordinate width (120-pixel screen)
CW, 3, colour width

Ports:
Clock  in  1  system clock, rising edge
Resetn  in  1  asynchronous active-low reset
ADDR  in  16  processor address
DOUT  in  16  processor write data
W  in  1  processor write strobe
RDATA  out  16  registered read data to the processor DIN mux
plot_x  out  XW  pixel x
plot_y  out  YW  pixel y
plot_color  out  CW  pixel colour
plot_we  out  1  pixel valid
plot_ready  in  1  framebuffer accepts the pixel this cycle
busy  out  1  engine drawing

Behaviour:
- Clocking and reset: one clock domain (Clock). Reset is asynchronous and active-low (Resetn).
- Reset values: all registers 0, RDATA=0, plot_we=0, busy=0, done=0, state=IDLE.
- Block select: sel = (ADDR[15:12]==BASE). Register offset = ADDR[2:0].
- Write map (write occurs when sel and W):
  - 0: START. Any data value starts a draw.
  - 1: X0 = DOUT[XW-1:0]
  - 2: Y0 = DOUT[YW-1:0]
  - 3: X1 = DOUT[XW-1:0]
  - 4: Y1 = DOUT[YW-1:0]
  - 5: COLOR = DOUT[CW-1:0]
  - 6 and 7: ignored.
- Register writes are accepted at any time. The engine works on private copies captured at LOAD, so writes while busy do not affect the line in progress.
- Read map: RDATA is updated every cycle that sel is high, one-cycle latency.
  - Offset 0 returns {14'b0, done, busy}.
  - Offsets 1-5 return the zero-extended register.
  - Offsets 6 and 7 return 0.
  - When sel is low, RDATA holds its previous value.
- START while busy is ignored: no restart, done unchanged.
- Internal width N = max(XW,YW). Error term is signed, N+2 bits.
- FSM:
  - IDLE: on START go to LOAD; busy goes high the next cycle; done clears.
  - LOAD: capture copies. steep = |Y1-Y0| > |X1-X0|. If steep, swap x and y of each endpoint.
  - ORDER: if x0 > x1, swap the endpoints. Compute dx = x1-x0 and dy = |y1-y0|; ystep = +1 if y0 < y1, else -1. Set err = -(dx>>1), x = x0, y = y0.
  - DRAW: plot_we=1. Output (plot_x, plot_y) = steep ? (y, x) : (x, y). plot_color = COLOR copy.
    - On plot_ready: if x == x1 go to IDLE, set done, clear busy. Otherwise x += 1 and err += dy; if the new err >= 0 then y += ystep and err -= dx.
    - While !plot_ready: all plot outputs are held stable.
- Latency: START written in cycle N gives LOAD in N+1, ORDER in N+2, first plot_we in N+3. With plot_ready held at 1, a line of dx+1 pixels completes in cycles N+3 .. N+3+dx.
- Endpoints are inclusive. A single point (equal endpoints) produces exactly 1 pixel.
- Simultaneous START and register write cannot occur (single address per cycle).
- Reset mid-draw: asynchronous return to reset values, plot_we drops immediately.

Decomposition:
- Package line_draw_pkg holds the state enum (IDLE, LOAD, ORDER, DRAW), the register offset constants (OFF_START..OFF_COLOR) and the status bit positions.
- Sub-module line_draw_engine holds the Bresenham FSM and datapath, taking start, endpoints and colour and producing plot and busy/done.
- line_draw_mmio keeps the address decode, the register file and the read mux.

Test Plan:
- Horizontal line: write X0=0, Y0=0, X1=3, Y1=0, COLOR=5, then START with plot_ready=1 -> pixels (0,0) (1,0) (2,0) (3,0), colour 5, in 4 consecutive cycles starting N+3. Status read then returns 16'h0002.
- Steep line: (0,0) to (1,3) -> pixels (0,0) (1,1) (1,2) (1,3).
- Reversed endpoints: (3,2) to (0,0) -> pixels (0,0) (1,1) (2,2) (3,2). A single point (7,7) to (7,7) gives exactly one pixel (7,7).
- Backpressure: hold plot_ready=0 for 3 cycles during the second pixel -> outputs stay frozen and no pixel is skipped or duplicated. START written during the draw is ignored, and an X1 write during the draw does not change the current line.
- Status readback: read offset 0 during the draw -> RDATA 16'h0001 one cycle after the address is presented. Read offset 3 -> the last X1 written.
- Reset mid-draw: drop Resetn at the second pixel -> plot_we=0 and busy=0 immediately, all registers return 0, and the next START draws from (0,0).
